switch_arbiter: RTL and testbench

Central crossbar arbiter for the 4-port switch. It watches the head-of-line packet of every input port FIFO and grants inputs to outputs without conflicts. It drives each port's FIFO read enable (grant) and each output port's 4:1 data mux select. Each packet is one 16-bit word {source[3:0], target[3:0], data[7:0]}, and the target is a one-hot or multi-hot output mask.

---
 rtl/switch_arbiter_if.sv | 30 +++
 rtl/switch_arbiter.sv | 148 ++++++++++++++
 tb/tb_switch_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/switch_arbiter_if.sv
// Arbiter-facing bundle for the 4-port switch: FIFO head-of-line requests in,
// grants, crossbar mux selects and output-valid strobes out.
interface switch_arbiter_if;
    logic [3:0] req;
    logic [3:0] target0;
    logic [3:0] target1;
    logic [3:0] target2;
    logic [3:0] target3;
    logic [3:0] grant;
    logic [1:0] mux_select0;
    logic [1:0] mux_select1;
    logic [1:0] mux_select2;
    logic [1:0] mux_select3;
    logic [3:0] out_valid;
    logic       drop_pulse;

    // Switch side: presents FIFO heads, consumes grants and mux controls.
    modport master (
        output req, target0, target1, target2, target3,
        input  grant, mux_select0, mux_select1, mux_select2, mux_select3,
        input  out_valid, drop_pulse
    );

    // Arbiter side.
    modport slave (
        input  req, target0, target1, target2, target3,
        output grant, mux_select0, mux_select1, mux_select2, mux_select3,
        output out_valid, drop_pulse
    );
endinterface

// File: rtl/switch_arbiter.sv
// Round-robin crossbar arbiter: grants conflict-free input->output sets in ARB,
// holds them for one XFER cycle while the granted FIFOs pop.
module switch_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned RST_PTR   = 0
) (
    input  logic            clk,
    input  logic            rst,
    switch_arbiter_if.slave bus
);
    localparam int unsigned NP = 4;
    localparam int unsigned PW = 2;

    if (NUM_PORTS != NP) begin : g_bad_num_ports
        $error("switch_arbiter supports only NUM_PORTS = 4");
    end

    typedef enum logic {ARB = 1'b0, XFER = 1'b1} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [NP-1:0]   r_grant;
    logic [NP-1:0]   r_out_valid;
    logic            r_drop;
    logic [PW-1:0]   r_mux_sel [NP];

    logic [NP-1:0]   w_target [NP];
    logic [NP-1:0]   w_claimed;
    logic [NP-1:0]   w_win;
    logic            w_drop_any;
    logic            w_found;
    logic [PW-1:0]   w_first;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_alloc_mux [NP];

    state_t          w_state_nxt;
    logic [PW-1:0]   w_ptr_nxt;
    logic [NP-1:0]   w_grant_nxt;
    logic [NP-1:0]   w_out_valid_nxt;
    logic            w_drop_nxt;
    logic [PW-1:0]   w_mux_nxt [NP];

    assign w_target[0] = bus.target0;
    assign w_target[1] = bus.target1;
    assign w_target[2] = bus.target2;
    assign w_target[3] = bus.target3;

    // Single-pass allocation in visit order; a multicast head claims all of its
    // outputs or nothing, and a zero-target head is granted purely to flush it.
    always_comb begin
        w_claimed   = '0;
        w_win       = '0;
        w_drop_any  = 1'b0;
        w_found     = 1'b0;
        w_first     = r_ptr;
        w_idx       = r_ptr;
        for (int j = 0; j < NP; j++) begin
            w_alloc_mux[j] = r_mux_sel[j];
        end
        for (int k = 0; k < NP; k++) begin
            w_idx = PW'(r_ptr + PW'(k));
            if (bus.req[w_idx]) begin
                if (w_target[w_idx] == '0) begin
                    w_win[w_idx] = 1'b1;
                    w_drop_any   = 1'b1;
                    if (!w_found) begin
                        w_found = 1'b1;
                        w_first = w_idx;
                    end
                end else if ((w_target[w_idx] & w_claimed) == '0) begin
                    w_win[w_idx] = 1'b1;
                    w_claimed    = w_claimed | w_target[w_idx];
                    for (int j = 0; j < NP; j++) begin
                        if (w_target[w_idx][j]) begin
                            w_alloc_mux[j] = w_idx;
                        end
                    end
                    if (!w_found) begin
                        w_found = 1'b1;
                        w_first = w_idx;
                    end
                end
            end
        end
    end

    // Next state and registered-output values.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_grant_nxt     = '0;
        w_out_valid_nxt = '0;
        w_drop_nxt      = 1'b0;
        for (int j = 0; j < NP; j++) begin
            w_mux_nxt[j] = r_mux_sel[j];
        end
        case (r_state)
            ARB: begin
                if (w_found) begin
                    w_state_nxt     = XFER;
                    w_grant_nxt     = w_win;
                    w_out_valid_nxt = w_claimed;
                    w_drop_nxt      = w_drop_any;
                    w_ptr_nxt       = PW'(w_first + PW'(1));
                    for (int j = 0; j < NP; j++) begin
                        w_mux_nxt[j] = w_alloc_mux[j];
                    end
                end
            end
            XFER: begin
                w_state_nxt = ARB;
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB;
            r_ptr       <= PW'(RST_PTR);
            r_grant     <= '0;
            r_out_valid <= '0;
            r_drop      <= 1'b0;
            for (int j = 0; j < NP; j++) begin
                r_mux_sel[j] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_drop      <= w_drop_nxt;
            for (int j = 0; j < NP; j++) begin
                r_mux_sel[j] <= w_mux_nxt[j];
            end
        end
    end

    assign bus.grant       = r_grant;
    assign bus.out_valid   = r_out_valid;
    assign bus.drop_pulse  = r_drop;
    assign bus.mux_select0 = r_mux_sel[0];
    assign bus.mux_select1 = r_mux_sel[1];
    assign bus.mux_select2 = r_mux_sel[2];
    assign bus.mux_select3 = r_mux_sel[3];
endmodule

// File: tb/tb_switch_arbiter.sv
// Bench for switch_arbiter: table of single-round allocations plus multi-cycle
// sequences, all checked through an expectation queue popped once per cycle.
module tb_switch_arbiter;
    logic clk;
    logic rst;

    switch_arbiter_if bus ();

    switch_arbiter #(.NUM_PORTS(4), .RST_PTR(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle; mux packed as {m3,m2,m1,m0}.
    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] ov;
        logic       drop;
        logic [7:0] mux;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] t0;
        logic [3:0] t1;
        logic [3:0] t2;
        logic [3:0] t3;
        exp_t       e;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs [9];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req_v);
        end
    endtask

    task automatic push_exp(input logic [3:0] g, input logic [3:0] ov, input logic d,
                            input logic [7:0] m);
        exp_t e;
        e.grant = g;
        e.ov    = ov;
        e.drop  = d;
        e.mux   = m;
        exp_q.push_back(e);
    endtask

    task automatic tick_check(input string tag);
        exp_t e;
        logic [7:0] m;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no expectation queued", tag);
        end else begin
            e = exp_q.pop_front();
            m = {bus.mux_select3, bus.mux_select2, bus.mux_select1, bus.mux_select0};
            check({tag, ".grant"},     16'(bus.grant),      16'(e.grant));
            check({tag, ".out_valid"}, 16'(bus.out_valid),  16'(e.ov));
            check({tag, ".drop"},      16'(bus.drop_pulse), 16'(e.drop));
            check({tag, ".mux"},       16'(m),              16'(e.mux));
        end
    endtask

    task automatic set_in(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        bus.req     = r;
        bus.target0 = a;
        bus.target1 = b;
        bus.target2 = c;
        bus.target3 = d;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            push_exp(4'b0, 4'b0, 1'b0, 8'h00);
            tick_check("reset");
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // req, t0, t1, t2, t3, {grant, out_valid, drop, mux}
        vecs[0] = '{4'b1111, 4'b0010, 4'b0001, 4'b1000, 4'b0100,
                    '{4'b1111, 4'b1111, 1'b0, 8'b10_11_00_01}};
        vecs[1] = '{4'b0011, 4'b1111, 4'b0001, 4'b0000, 4'b0000,
                    '{4'b0001, 4'b1111, 1'b0, 8'b00_00_00_00}};
        vecs[2] = '{4'b0011, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                    '{4'b0001, 4'b0100, 1'b0, 8'b00_00_00_00}};
        vecs[3] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                    '{4'b0100, 4'b0000, 1'b1, 8'b00_00_00_00}};
        vecs[4] = '{4'b1010, 4'b0000, 4'b0011, 4'b0000, 4'b1100,
                    '{4'b1010, 4'b1111, 1'b0, 8'b11_11_01_01}};
        vecs[5] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000,
                    '{4'b1000, 4'b1000, 1'b0, 8'b11_00_00_00}};
        vecs[6] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0110,
                    '{4'b1001, 4'b0110, 1'b1, 8'b00_11_11_00}};
        vecs[7] = '{4'b0011, 4'b0001, 4'b0011, 4'b0000, 4'b0000,
                    '{4'b0001, 4'b0001, 1'b0, 8'b00_00_00_00}};
        vecs[8] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                    '{4'b0000, 4'b0000, 1'b0, 8'b00_00_00_00}};

        rst = 1'b1;
        set_in(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

        // Requests present during reset; pointer starts at 0, then unicast conflict alternates.
        set_in(4'b0011, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        do_reset(2);
        push_exp(4'b0001, 4'b0100, 1'b0, 8'b00_00_00_00); tick_check("conf_r1");
        push_exp(4'b0000, 4'b0000, 1'b0, 8'b00_00_00_00); tick_check("conf_arb1");
        push_exp(4'b0010, 4'b0100, 1'b0, 8'b00_01_00_00); tick_check("conf_r2");
        push_exp(4'b0000, 4'b0000, 1'b0, 8'b00_01_00_00); tick_check("conf_arb2");
        push_exp(4'b0001, 4'b0100, 1'b0, 8'b00_00_00_00); tick_check("conf_r3");
        push_exp(4'b0000, 4'b0000, 1'b0, 8'b00_00_00_00); tick_check("conf_arb3");
        push_exp(4'b0010, 4'b0100, 1'b0, 8'b00_01_00_00); tick_check("conf_r4");

        // Single-round allocations from a freshly reset pointer.
        for (int v = 0; v < 9; v++) begin
            set_in(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
            do_reset(1);
            set_in(vecs[v].req, vecs[v].t0, vecs[v].t1, vecs[v].t2, vecs[v].t3);
            exp_q.push_back(vecs[v].e);
            tick_check($sformatf("vec%0d_xfer", v));
            set_in(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
            push_exp(4'b0, 4'b0, 1'b0, vecs[v].e.mux);
            tick_check($sformatf("vec%0d_after", v));
        end

        // Multicast served atomically, then the blocked unicast, then a drop holding mux.
        set_in(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        do_reset(1);
        set_in(4'b0011, 4'b1111, 4'b0001, 4'b0000, 4'b0000);
        push_exp(4'b0001, 4'b1111, 1'b0, 8'b00_00_00_00); tick_check("mc_r1");
        push_exp(4'b0000, 4'b0000, 1'b0, 8'b00_00_00_00); tick_check("mc_arb");
        push_exp(4'b0010, 4'b0001, 1'b0, 8'b00_00_00_01); tick_check("mc_r2");
        set_in(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        push_exp(4'b0000, 4'b0000, 1'b0, 8'b00_00_00_01); tick_check("drop_arb");
        push_exp(4'b0100, 4'b0000, 1'b1, 8'b00_00_00_01); tick_check("drop_xfer");
        set_in(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        push_exp(4'b0000, 4'b0000, 1'b0, 8'b00_00_00_01); tick_check("drop_clear");

        // Reset on the ARB->XFER edge: no grant, pointer back to its reset value.
        do_reset(1);
        set_in(4'b0011, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        push_exp(4'b0001, 4'b0100, 1'b0, 8'b00_00_00_00); tick_check("mid_r1");
        push_exp(4'b0000, 4'b0000, 1'b0, 8'b00_00_00_00); tick_check("mid_arb");
        do_reset(1);
        push_exp(4'b0001, 4'b0100, 1'b0, 8'b00_00_00_00); tick_check("mid_ptr");
        push_exp(4'b0000, 4'b0000, 1'b0, 8'b00_00_00_00); tick_check("mid_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
